// File: rtl/router_sync_n_if.sv
// -----------------------------------------------------------------------------
// router_sync_n_if
//   Bundles the router-synchronizer handshake signals between the router FSM,
//   the NUM_PORTS output FIFOs and the synchronizer itself.
//
//   master : drives the synchronizer inputs (router FSM / FIFO side).
//   slave  : the synchronizer (router_sync_n).
//
//   Signals
//     detect_add     header cycle; data_in holds the destination
//     write_enb_reg  router FSM requests a FIFO write
//     data_in        destination address (ADDR_W)
//     read_enb       per-port read strobe from downstream
//     empty / full   per-FIFO status flags
//     vld_out        per-port data-valid
//     write_enb      one-hot write enable to the selected FIFO
//     fifo_full      full flag of the selected FIFO
//     addr_err       last header carried an out-of-range address
//     soft_rst       one-cycle soft-reset pulse per FIFO
//     clr_log        clears timeout_log (SYNC_TIMEOUT_LOG_EN builds only)
//     timeout_log    sticky per-port timeout record (SYNC_TIMEOUT_LOG_EN only)
// -----------------------------------------------------------------------------
interface router_sync_n_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = $clog2(NUM_PORTS)
);
  logic                 detect_add;
  logic                 write_enb_reg;
  logic [ADDR_W-1:0]    data_in;
  logic [NUM_PORTS-1:0] read_enb;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] write_enb;
  logic                 fifo_full;
  logic                 addr_err;
  logic [NUM_PORTS-1:0] soft_rst;
`ifdef SYNC_TIMEOUT_LOG_EN
  logic                 clr_log;
  logic [NUM_PORTS-1:0] timeout_log;

  modport master (
    output detect_add, write_enb_reg, data_in, read_enb, empty, full, clr_log,
    input  vld_out, write_enb, fifo_full, addr_err, soft_rst, timeout_log
  );

  modport slave (
    input  detect_add, write_enb_reg, data_in, read_enb, empty, full, clr_log,
    output vld_out, write_enb, fifo_full, addr_err, soft_rst, timeout_log
  );
`else
  modport master (
    output detect_add, write_enb_reg, data_in, read_enb, empty, full,
    input  vld_out, write_enb, fifo_full, addr_err, soft_rst
  );

  modport slave (
    input  detect_add, write_enb_reg, data_in, read_enb, empty, full,
    output vld_out, write_enb, fifo_full, addr_err, soft_rst
  );
`endif
endinterface

// File: rtl/router_sync_n.sv
// -----------------------------------------------------------------------------
// router_sync_n
//   Synchronizer between the router register/FSM and NUM_PORTS output FIFOs.
//   - Latches the destination address on the header cycle (detect_add).
//   - Steers write_enb_reg to the addressed FIFO and reflects its full flag.
//   - vld_out[i] = ~empty[i].
//   - Per-channel watchdog: a FIFO holding data that nobody reads for
//     TIMEOUT consecutive cycles receives a one-cycle soft_rst pulse.
//
//   Ports
//     clock  : single clock, all logic on posedge
//     reset  : synchronous, active-high
//     bus    : router_sync_n_if.slave (see interface header for signal list)
//
//   Optional feature (macro SYNC_TIMEOUT_LOG_EN)
//     Adds clr_log / timeout_log: a sticky per-port flag set the cycle after
//     that port's soft_rst pulse, cleared by reset or clr_log (set wins).
//
//   Channel FSM
//     state | meaning
//     IDLE  | FIFO empty or being read; counter held at 0
//     COUNT | FIFO valid and unread; cnt = idle cycles seen so far
//     FIRE  | soft_rst asserted this cycle; FIFO is emptying, not re-timed
// -----------------------------------------------------------------------------
module router_sync_n #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = $clog2(NUM_PORTS),
  parameter int TIMEOUT   = 30,
  parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic           clock,
  input  logic           reset,
  router_sync_n_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } ch_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ADDR_W-1:0]    addr_q;
  logic                 addr_vld;
  logic                 addr_vld_next;
  logic                 addr_err_q;

  logic [NUM_PORTS-1:0] vld;
  logic [NUM_PORTS-1:0] idle;
  logic [NUM_PORTS-1:0] write_enb_c;
  logic                 fifo_full_c;
  logic [NUM_PORTS-1:0] soft_rst_q;

  ch_state_t            state [NUM_PORTS];
  logic [CNT_W-1:0]     cnt   [NUM_PORTS];

  // ---------------------------------------------------------------------------
  // Address latch
  // ---------------------------------------------------------------------------
  assign addr_vld_next = (32'(bus.data_in) < 32'(NUM_PORTS));

  // addr_q resets to all-ones so a stale value can never alias port 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '1;
      addr_vld   <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (bus.detect_add) begin
      addr_q     <= bus.data_in;
      addr_vld   <= addr_vld_next;
      addr_err_q <= !addr_vld_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Steering: driven from the registered address only, so a header and a
  // write in the same cycle still go to the previously latched port.
  // An invalid address drops the packet silently.
  // ---------------------------------------------------------------------------
  always_comb begin
    write_enb_c = '0;
    fifo_full_c = 1'b0;
    if (addr_vld) begin
      write_enb_c = NUM_PORTS'(bus.write_enb_reg) << addr_q;
      fifo_full_c = bus.full[addr_q];
    end
  end

  assign vld  = ~bus.empty;
  assign idle = vld & ~bus.read_enb;

  // ---------------------------------------------------------------------------
  // Per-channel watchdog. cnt is loaded with 1 on the first idle cycle, so the
  // compare against TIMEOUT-1 fires on the TIMEOUT-th consecutive idle cycle
  // and the counter never needs to hold TIMEOUT itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      soft_rst_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        soft_rst_q[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            if (idle[i]) begin
              state[i] <= COUNT;
              cnt[i]   <= CNT_ONE;
            end else begin
              cnt[i]   <= '0;
            end
          end
          COUNT: begin
            if (!idle[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]      <= FIRE;
              cnt[i]        <= '0;
              soft_rst_q[i] <= 1'b1;
            end else begin
              cnt[i]   <= cnt[i] + CNT_ONE;
            end
          end
          FIRE: begin
            // The FIFO empties on this edge; do not sample idle here.
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

`ifdef SYNC_TIMEOUT_LOG_EN
  logic [NUM_PORTS-1:0] timeout_log_q;

  // soft_rst_q is already registered, so OR-ing it in sets the flag the cycle
  // after the pulse; the OR after the clear mask makes set win over clr_log.
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_log_q <= '0;
    end else begin
      timeout_log_q <= (timeout_log_q & ~{NUM_PORTS{bus.clr_log}}) | soft_rst_q;
    end
  end

  assign bus.timeout_log = timeout_log_q;
`endif

  assign bus.vld_out   = vld;
  assign bus.write_enb = write_enb_c;
  assign bus.fifo_full = fifo_full_c;
  assign bus.addr_err  = addr_err_q;
  assign bus.soft_rst  = soft_rst_q;

endmodule
